count_checker: RTL and testbench
================================

# count_checker

Downstream monitor for the 4-bit free-running counter. Samples `count` every `clk`, locks onto the increment-by-one sequence, reports each mismatch as a single-entry valid/ready error record, and counts wrap-arounds (15 -> 0). It sits beside the counter in the top-level counter assembly and feeds the bench scoreboard and status logic.

## Interface
- `WIDTH`, 4: width of the monitored count.
- `WRAP_W`, 8: width of the wrap counter.
- `ERRC_W`, 8: width of the saturating error counter.
- `LOCK_CYCLES`, 2: consecutive correct increments required to lock (1..15).

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `count`  in  WIDTH  upstream counter value.
- `locked`  out  1  checker is tracking the sequence.
- `wrap_pulse`  out  1  one-cycle pulse per detected wrap.
- `wrap_cnt`  out  WRAP_W  number of wraps, modulo 2^WRAP_W.
- `err_valid`  out  1  error record available.
- `err_ready`  in  1  consumer accepts record.
- `err_expected`  out  WIDTH  value that was expected.
- `err_actual`  out  WIDTH  value actually sampled.
- `err_ovf`  out  1  sticky: an error was dropped because the slot was full.
- `err_cnt`  out  ERRC_W  total mismatches detected, saturating at all-ones.

## Operation
- Internal `prev` register holds last sampled `count`; `expected = prev + 1` modulo 2^WIDTH (15 + 1 = 0).
- States: SYNC, LOCKED.
- SYNC: each cycle, if `count == expected`, increment `match_run`, else clear it to 0; first cycle after reset only loads `prev` (no compare). When `match_run` reaches `LOCK_CYCLES`, go to LOCKED. No errors reported in SYNC.
- LOCKED: each cycle compare `count` to `expected`. Mismatch -> raise error, return to SYNC with `match_run = 0`, `prev = count`. Match -> stay.
- Wrap: in LOCKED, `prev == 2^WIDTH-1` and `count == 0` -> `wrap_pulse` and `wrap_cnt + 1` (wraps to 0 at 2^WRAP_W).
- Error slot: single entry. Detected error with slot empty, or with slot full and `err_ready` high the same cycle -> load `{expected, count}`, `err_valid = 1`. Slot full and `err_ready` low -> record dropped, `err_ovf` set; slot contents unchanged.
- `err_valid` clears on `err_valid && err_ready` unless a new error loads that same cycle.
- `err_cnt` increments on every detected error, including dropped ones; holds at max.
- `err_ovf` cleared only by `rst`.

## Timing
- Reset: all outputs 0; state SYNC; `prev`, `match_run` 0; first post-reset sample is load-only.
- `count` sampled at posedge N; `wrap_pulse`, `err_valid`, `err_cnt`, state change visible after posedge N (one-cycle latency), registered outputs only.
- `locked` rises the cycle after the `LOCK_CYCLES`-th consecutive match; falls the cycle after the mismatch sample (same cycle `err_valid` rises).
- `err_expected`/`err_actual` stable while `err_valid` high and `err_ready` low.
- `rst` mid-operation overrides everything that cycle, including pending handshake (record discarded).
- Upstream counter reset (count forced 0 without checker reset) is an ordinary mismatch unless `prev == 15`.

## Structure
- Package `count_chk_pkg`: `typedef enum logic {ST_SYNC, ST_LOCKED} chk_state_t`; `typedef struct packed` error record `{expected, actual}` for WIDTH=4; default-parameter constants.
- One sub-module: `err_report_slot` — single-entry valid/ready holding register with overflow flag; top handles compare, FSM, wrap and error counters.

## Test plan
- Reset, then count 0,1,2,3,... -> `locked` = 1 after the 3rd sample (LOCK_CYCLES=2), no `err_valid`.
- Locked, count 14,15,0,1 -> single `wrap_pulse` the cycle after 0 is sampled, `wrap_cnt` 0 -> 1.
- Locked at 5, inject 9 -> `err_valid`=1, `err_expected`=6, `err_actual`=9, `err_cnt`=1, `locked`=0; relock after 10, 11.
- Hold `err_ready`=0, two errors (second after relock) -> first record retained, `err_ovf`=1, `err_cnt`=2.
- `err_ready` high same cycle as a new error -> old record retires, new record loaded, `err_valid` stays 1, no overflow.
- Assert `rst` while `err_valid`=1 and locked -> next cycle all outputs 0, state SYNC.

Source files
------------

// File: rtl/count_checker_pkg.sv
// Shared types and default parameters for the count_checker monitor.
// Imported by the interface, the error slot and the top-level checker.
package count_chk_pkg;

  localparam int unsigned CountW     = 4;
  localparam int unsigned WrapW      = 8;
  localparam int unsigned ErrcW      = 8;
  localparam int unsigned LockCycles = 2;
  // Wide enough for the largest legal lock threshold (15).
  localparam int unsigned RunW       = 4;

  typedef enum logic {
    ST_SYNC,
    ST_LOCKED
  } chk_state_t;

  typedef struct packed {
    logic [CountW-1:0] expected;
    logic [CountW-1:0] actual;
  } err_rec_t;

  function automatic logic [RunW-1:0] run_next(input logic [RunW-1:0] run, input logic hit);
    return hit ? run + RunW'(1) : '0;
  endfunction

endpackage

// File: rtl/count_checker_if.sv
// Valid/ready error-record channel from the checker to its consumer.
// The checker owns valid and the record; the consumer owns ready.
interface count_checker_if
  import count_chk_pkg::*;
#(
  parameter int unsigned WIDTH = CountW
);

  logic             err_valid;
  logic             err_ready;
  logic [WIDTH-1:0] err_expected;
  logic [WIDTH-1:0] err_actual;

  modport master (
    output err_valid,
    output err_expected,
    output err_actual,
    input  err_ready
  );

  modport slave (
    input  err_valid,
    input  err_expected,
    input  err_actual,
    output err_ready
  );

endinterface

// File: rtl/count_checker_err_report_slot.sv
// Single-entry valid/ready holding register for error records.
// A record arriving while the slot is full and not draining is dropped and flagged sticky.
module err_report_slot
  import count_chk_pkg::*;
#(
  parameter type rec_t = err_rec_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  rec_t rec_i,
  input  logic ready_i,
  output logic valid_o,
  output rec_t rec_o,
  output logic ovf_o
);

  logic valid_q, valid_d;
  rec_t rec_q, rec_d;
  logic ovf_q, ovf_d;
  logic load;
  logic drop;

  always_comb begin
    // The slot frees up in the same cycle it is drained, so a push can replace a retiring record.
    load    = push_i && (!valid_q || ready_i);
    drop    = push_i && valid_q && !ready_i;
    valid_d = valid_q;
    rec_d   = rec_q;
    ovf_d   = ovf_q || drop;
    if (load) begin
      valid_d = 1'b1;
      rec_d   = rec_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rec_q   <= rec_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o = valid_q;
  assign rec_o   = rec_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/count_checker.sv
// Monitor for a free-running up-counter: locks onto the +1 sequence, reports mismatches
// through a single-entry error slot, and counts wrap-arounds.
module count_checker
  import count_chk_pkg::*;
#(
  parameter int unsigned WIDTH       = CountW,
  parameter int unsigned WRAP_W      = WrapW,
  parameter int unsigned ERRC_W      = ErrcW,
  parameter int unsigned LOCK_CYCLES = LockCycles
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      count_i,
  output logic                  locked_o,
  output logic                  wrap_pulse_o,
  output logic [WRAP_W-1:0]     wrap_cnt_o,
  count_checker_if.master       err_if,
  output logic                  err_ovf_o,
  output logic [ERRC_W-1:0]     err_cnt_o
);

  typedef struct packed {
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] actual;
  } rec_t;

  localparam logic [RunW-1:0] LockRun = RunW'(LOCK_CYCLES);

  chk_state_t        st_q, st_d;
  logic [WIDTH-1:0]  prev_q, prev_d;
  logic [RunW-1:0]   run_q, run_d;
  logic              first_q, first_d;
  logic              wrap_pulse_q, wrap_pulse_d;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [ERRC_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0]  expected;
  logic              hit;
  logic              err_det;
  rec_t              err_rec;
  rec_t              slot_rec;
  logic              slot_valid;
  logic              slot_ovf;

  always_comb begin
    st_d         = st_q;
    prev_d       = count_i;
    run_d        = run_q;
    first_d      = 1'b0;
    wrap_pulse_d = 1'b0;
    wrap_cnt_d   = wrap_cnt_q;
    err_cnt_d    = err_cnt_q;
    err_det      = 1'b0;
    expected     = prev_q + WIDTH'(1);
    hit          = (count_i == expected);

    // The first sample after reset only seeds prev; there is nothing to compare it against.
    if (!first_q) begin
      unique case (st_q)
        ST_SYNC: begin
          run_d = run_next(run_q, hit);
          if (run_d == LockRun) begin
            st_d  = ST_LOCKED;
            run_d = '0;
          end
        end
        ST_LOCKED: begin
          if (!hit) begin
            err_det = 1'b1;
            st_d    = ST_SYNC;
            run_d   = '0;
          end else if ((prev_q == '1) && (count_i == '0)) begin
            wrap_pulse_d = 1'b1;
            wrap_cnt_d   = wrap_cnt_q + WRAP_W'(1);
          end
        end
        default: st_d = ST_SYNC;
      endcase
    end

    // Dropped records still count; the counter saturates rather than wrapping.
    if (err_det && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERRC_W'(1);
    end

    err_rec.expected = expected;
    err_rec.actual   = count_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q         <= ST_SYNC;
      prev_q       <= '0;
      run_q        <= '0;
      first_q      <= 1'b1;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      st_q         <= st_d;
      prev_q       <= prev_d;
      run_q        <= run_d;
      first_q      <= first_d;
      wrap_pulse_q <= wrap_pulse_d;
      wrap_cnt_q   <= wrap_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  err_report_slot #(
    .rec_t (rec_t)
  ) u_slot (
    .clk     (clk),
    .rst     (rst),
    .push_i  (err_det),
    .rec_i   (err_rec),
    .ready_i (err_if.err_ready),
    .valid_o (slot_valid),
    .rec_o   (slot_rec),
    .ovf_o   (slot_ovf)
  );

  assign locked_o            = (st_q == ST_LOCKED);
  assign wrap_pulse_o        = wrap_pulse_q;
  assign wrap_cnt_o          = wrap_cnt_q;
  assign err_cnt_o           = err_cnt_q;
  assign err_ovf_o           = slot_ovf;
  assign err_if.err_valid    = slot_valid;
  assign err_if.err_expected = slot_rec.expected;
  assign err_if.err_actual   = slot_rec.actual;

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: checks lock, wrap, error records, overflow,
// saturation and mid-run reset; error records are matched against a scoreboard queue.
module tb_count_checker;
  import count_chk_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] count;
  logic       locked;
  logic       wrap_pulse;
  logic [7:0] wrap_cnt;
  logic       err_ovf;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  int exp_errs = 0;
  logic [3:0] v;
  err_rec_t sb_q[$];

  count_checker_if eif ();

  count_checker dut (
    .clk          (clk),
    .rst          (rst),
    .count_i      (count),
    .locked_o     (locked),
    .wrap_pulse_o (wrap_pulse),
    .wrap_cnt_o   (wrap_cnt),
    .err_if       (eif),
    .err_ovf_o    (err_ovf),
    .err_cnt_o    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample; any handshake completing at the coming edge is scored first.
  task automatic cyc(input logic [3:0] c, input logic rdy);
    err_rec_t want;
    @(negedge clk);
    count         = c;
    eif.err_ready = rdy;
    #1;
    if (eif.err_valid && eif.err_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_record", 32'(1), 32'(0));
      end else begin
        want = sb_q.pop_front();
        check("sb_expected", 32'(eif.err_expected), 32'(want.expected));
        check("sb_actual", 32'(eif.err_actual), 32'(want.actual));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_rec(input logic [3:0] e, input logic [3:0] a);
    err_rec_t r;
    r.expected = e;
    r.actual   = a;
    sb_q.push_back(r);
  endtask

  initial begin
    rst           = 1'b1;
    count         = '0;
    eif.err_ready = 1'b0;
    cyc(4'd0, 1'b0);
    cyc(4'd0, 1'b0);
    check("rst_locked", 32'(locked), 32'(0));
    check("rst_wrap_pulse", 32'(wrap_pulse), 32'(0));
    check("rst_wrap_cnt", 32'(wrap_cnt), 32'(0));
    check("rst_err_valid", 32'(eif.err_valid), 32'(0));
    check("rst_err_expected", 32'(eif.err_expected), 32'(0));
    check("rst_err_actual", 32'(eif.err_actual), 32'(0));
    check("rst_err_ovf", 32'(err_ovf), 32'(0));
    check("rst_err_cnt", 32'(err_cnt), 32'(0));

    // Lock-on after the third sample.
    rst = 1'b0;
    cyc(4'd0, 1'b0);
    cyc(4'd1, 1'b0);
    check("lock_not_yet", 32'(locked), 32'(0));
    cyc(4'd2, 1'b0);
    check("lock_after_3", 32'(locked), 32'(1));
    check("lock_no_err", 32'(eif.err_valid), 32'(0));

    for (int i = 3; i <= 15; i++) cyc(4'(i), 1'b0);
    check("pre_wrap_pulse", 32'(wrap_pulse), 32'(0));
    cyc(4'd0, 1'b0);
    check("wrap_pulse", 32'(wrap_pulse), 32'(1));
    check("wrap_cnt_1", 32'(wrap_cnt), 32'(1));
    cyc(4'd1, 1'b0);
    check("wrap_pulse_single", 32'(wrap_pulse), 32'(0));
    check("wrap_cnt_hold", 32'(wrap_cnt), 32'(1));

    // Mismatch while locked at 5.
    for (int i = 2; i <= 5; i++) cyc(4'(i), 1'b0);
    cyc(4'd9, 1'b0);
    push_rec(4'd6, 4'd9);
    exp_errs++;
    check("err1_valid", 32'(eif.err_valid), 32'(1));
    check("err1_expected", 32'(eif.err_expected), 32'(6));
    check("err1_actual", 32'(eif.err_actual), 32'(9));
    check("err1_cnt", 32'(err_cnt), 32'(1));
    check("err1_unlocked", 32'(locked), 32'(0));
    cyc(4'd10, 1'b0);
    check("relock_pending", 32'(locked), 32'(0));
    cyc(4'd11, 1'b0);
    check("relock", 32'(locked), 32'(1));
    check("err1_stable_exp", 32'(eif.err_expected), 32'(6));
    check("err1_stable_act", 32'(eif.err_actual), 32'(9));

    // New error in the same cycle the old record retires.
    cyc(4'd12, 1'b0);
    cyc(4'd5, 1'b1);
    push_rec(4'd13, 4'd5);
    exp_errs++;
    check("swap_valid", 32'(eif.err_valid), 32'(1));
    check("swap_expected", 32'(eif.err_expected), 32'(13));
    check("swap_actual", 32'(eif.err_actual), 32'(5));
    check("swap_no_ovf", 32'(err_ovf), 32'(0));
    check("swap_cnt", 32'(err_cnt), 32'(2));

    // Second error with the slot full and ready low is dropped.
    cyc(4'd6, 1'b0);
    cyc(4'd7, 1'b0);
    cyc(4'd8, 1'b0);
    cyc(4'd0, 1'b0);
    exp_errs++;
    check("drop_ovf", 32'(err_ovf), 32'(1));
    check("drop_cnt", 32'(err_cnt), 32'(3));
    check("drop_keep_exp", 32'(eif.err_expected), 32'(13));
    check("drop_keep_act", 32'(eif.err_actual), 32'(5));
    check("drop_unlocked", 32'(locked), 32'(0));
    cyc(4'd1, 1'b0);
    cyc(4'd2, 1'b0);
    check("drop_relock", 32'(locked), 32'(1));

    cyc(4'd3, 1'b1);
    check("drain_valid", 32'(eif.err_valid), 32'(0));
    check("drain_locked", 32'(locked), 32'(1));

    // Counter reset to 0 from 15 is a legitimate wrap, not an error.
    for (int i = 4; i <= 15; i++) cyc(4'(i), 1'b0);
    cyc(4'd0, 1'b0);
    check("wrap2_pulse", 32'(wrap_pulse), 32'(1));
    check("wrap2_cnt", 32'(wrap_cnt), 32'(2));
    check("wrap2_no_err", 32'(err_cnt), 32'(3));

    // Drive enough errors to saturate the error counter.
    v = 4'd0;
    for (int i = 0; i < 260; i++) begin
      cyc(4'(v + 4'd5), 1'b1);
      push_rec(4'(v + 4'd1), 4'(v + 4'd5));
      if (exp_errs < 255) exp_errs++;
      cyc(4'(v + 4'd6), 1'b1);
      cyc(4'(v + 4'd7), 1'b1);
      v = 4'(v + 4'd7);
    end
    check("sat_cnt", 32'(err_cnt), 32'(exp_errs));
    check("sat_cnt_max", 32'(err_cnt), 32'(255));
    check("sat_wrap_cnt", 32'(wrap_cnt), 32'(2));
    check("sat_locked", 32'(locked), 32'(1));
    check("sat_sb_empty", 32'(sb_q.size()), 32'(0));

    // Reset while locked with a pending record.
    cyc(4'(v + 4'd5), 1'b0);
    push_rec(4'(v + 4'd1), 4'(v + 4'd5));
    cyc(4'(v + 4'd6), 1'b0);
    cyc(4'(v + 4'd7), 1'b0);
    check("pre_rst_locked", 32'(locked), 32'(1));
    check("pre_rst_valid", 32'(eif.err_valid), 32'(1));
    rst = 1'b1;
    cyc(4'(v + 4'd8), 1'b0);
    sb_q.delete();
    check("mid_rst_locked", 32'(locked), 32'(0));
    check("mid_rst_valid", 32'(eif.err_valid), 32'(0));
    check("mid_rst_exp", 32'(eif.err_expected), 32'(0));
    check("mid_rst_act", 32'(eif.err_actual), 32'(0));
    check("mid_rst_ovf", 32'(err_ovf), 32'(0));
    check("mid_rst_cnt", 32'(err_cnt), 32'(0));
    check("mid_rst_wrap_cnt", 32'(wrap_cnt), 32'(0));
    check("mid_rst_wrap_pulse", 32'(wrap_pulse), 32'(0));

    // First post-reset sample is load-only: 1,2 alone must not lock.
    rst = 1'b0;
    cyc(4'd1, 1'b0);
    cyc(4'd2, 1'b0);
    check("load_only_no_lock", 32'(locked), 32'(0));
    cyc(4'd3, 1'b0);
    check("load_only_lock", 32'(locked), 32'(1));
    check("post_rst_no_err", 32'(eif.err_valid), 32'(0));
    check("final_sb_empty", 32'(sb_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
